// File: rtl/mod_n_tick_counter.sv
// -----------------------------------------------------------------------------
// mod_n_tick_counter
//
// Parametrised modulo-N counter for one digit stage of the alarm/clock
// datapath. Runs from a single clock. An internal prescaler produces a
// one-cycle tick enable every TICK_DIV enabled cycles. The counter
// auto-steps up on that tick or on a cascade pulse from a lower stage. It
// also takes edge-detected manual up/down steps, a hold, and a saturating
// synchronous load. Registered carry and borrow pulses mark wraps, so digit
// stages can be chained through carry -> cascade_in.
//
// Parameters
//   WIDTH       width of count / load_value (2**WIDTH >= MODULUS)
//   MODULUS     count range 0..MODULUS-1 (>= 2)
//   TICK_DIV    clk cycles per auto tick (>= 1; 1 = tick every enabled cycle)
//   RESET_VALUE count after reset (< MODULUS)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   en          enables prescaler and auto counting
//   hold        freezes count against auto/manual steps (load still acts)
//   count_up    manual increment, rising-edge detected
//   count_down  manual decrement, rising-edge detected
//   load        synchronous load strobe
//   load_value  value to load (saturated to MODULUS-1)
//   cascade_in  step-up pulse from a lower stage (auto step)
//   count       current value
//   carry       one-cycle pulse on an up-wrap MODULUS-1 -> 0
//   borrow      one-cycle pulse on a down-wrap 0 -> MODULUS-1
//   tick        one-cycle registered prescaler tick
// -----------------------------------------------------------------------------
module mod_n_tick_counter #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 10,
  parameter int TICK_DIV    = 100000000,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hold,
  input  logic             count_up,
  input  logic             count_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             cascade_in,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             tick
);

  // The prescaler needs at least one bit, even when TICK_DIV is 1.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] CNT_RST  = WIDTH'(RESET_VALUE);

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN
  } step_t;

  logic [PW-1:0]    prescaler;
  logic             tick_int;
  logic             up_q;
  logic             down_q;
  logic             up_edge;
  logic             down_edge;
  step_t            step;
  logic [WIDTH-1:0] count_next;
  logic             carry_next;
  logic             borrow_next;

  assign tick_int  = en && (prescaler == PRE_LAST);
  assign up_edge   = count_up & ~up_q;
  assign down_edge = count_down & ~down_q;

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (en) begin
      prescaler <= tick_int ? '0 : prescaler + PW'(1);
    end
  end

  // The edge history follows the raw inputs every cycle, even under hold or
  // with en low. A press made while frozen is therefore not replayed later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      up_q   <= count_up;
      down_q <= count_down;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the if/case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    step        = STEP_NONE;
    count_next  = count;
    carry_next  = 1'b0;
    borrow_next = 1'b0;

    if (load) begin
      // An out-of-range load saturates at the top of the range.
      count_next = (load_value <= CNT_MAX) ? load_value : CNT_MAX;
    end else if (!hold) begin
      if (up_edge ^ down_edge) begin
        // A manual step uses up any tick in the same cycle. That tick is
        // dropped, not deferred.
        step = up_edge ? STEP_UP : STEP_DOWN;
      end else if (!up_edge && !down_edge && en && (tick_int || cascade_in)) begin
        step = STEP_UP;
      end
    end

    // The wraps compare against MODULUS-1 explicitly. The counter never relies
    // on 2**WIDTH overflow, which only matches when MODULUS is a power of two.
    case (step)
      STEP_UP: begin
        if (count == CNT_MAX) begin
          count_next = '0;
          carry_next = 1'b1;
        end else begin
          count_next = count + WIDTH'(1);
        end
      end
      STEP_DOWN: begin
        if (count == '0) begin
          count_next  = CNT_MAX;
          borrow_next = 1'b1;
        end else begin
          count_next = count - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // carry and borrow are registered with count, so a pulse shows in the same
  // cycle as the wrapped value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= CNT_RST;
      carry  <= 1'b0;
      borrow <= 1'b0;
      tick   <= 1'b0;
    end else begin
      count  <= count_next;
      carry  <= carry_next;
      borrow <= borrow_next;
      tick   <= tick_int;
    end
  end

endmodule

// File: tb/tb_mod_n_tick_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_n_tick_counter
//
// Directed bench for mod_n_tick_counter.
//   dut   : MODULUS=10, TICK_DIV=4, RESET_VALUE=3 (reset, table, auto, corners)
//   c0/c1 : MODULUS=10 -> MODULUS=6 cascade pair (c0.carry -> c1.cascade_in)
// -----------------------------------------------------------------------------
module tb_mod_n_tick_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, hold, up, down, load, cin;
  logic [3:0] lv;
  logic [3:0] count;
  logic       carry, borrow, tick;

  logic       c_en, c_load;
  logic [3:0] c_lv;
  logic [3:0] c0_count;
  logic       c0_carry, c0_borrow, c0_tick;
  logic [2:0] c1_count;
  logic       c1_carry, c1_borrow, c1_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_n_tick_counter #(.WIDTH(4), .MODULUS(10), .TICK_DIV(4), .RESET_VALUE(3)) dut (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .count_up(up), .count_down(down),
    .load(load), .load_value(lv), .cascade_in(cin),
    .count(count), .carry(carry), .borrow(borrow), .tick(tick)
  );

  mod_n_tick_counter #(.WIDTH(4), .MODULUS(10), .TICK_DIV(4), .RESET_VALUE(0)) c0 (
    .clk(clk), .rst(rst), .en(c_en), .hold(1'b0), .count_up(1'b0), .count_down(1'b0),
    .load(c_load), .load_value(c_lv), .cascade_in(1'b0),
    .count(c0_count), .carry(c0_carry), .borrow(c0_borrow), .tick(c0_tick)
  );

  mod_n_tick_counter #(.WIDTH(3), .MODULUS(6), .TICK_DIV(1000), .RESET_VALUE(0)) c1 (
    .clk(clk), .rst(rst), .en(c_en), .hold(1'b0), .count_up(1'b0), .count_down(1'b0),
    .load(1'b0), .load_value(3'd0), .cascade_in(c0_carry),
    .count(c1_count), .carry(c1_carry), .borrow(c1_borrow), .tick(c1_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       hold, up, down, load;
    logic [3:0] lv;
    logic [3:0] exp_count;
    logic       exp_carry, exp_borrow;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic h, input logic u, input logic d, input logic l,
                     input logic [3:0] v, input logic [3:0] c,
                     input logic cy, input logic bw);
    vec_t x;
    x.hold = h; x.up = u; x.down = d; x.load = l; x.lv = v;
    x.exp_count = c; x.exp_carry = cy; x.exp_borrow = bw;
    vecs.push_back(x);
  endtask

  initial begin
    int exp_cnt;
    int n_ticks;
    int n_carry;
    logic exp_tk, exp_cy;

    //      hold up dn ld  lv   cnt cy bw      (en=0 throughout)
    add(0, 0, 0, 1,  0,   0, 0, 0);  // load 0
    add(0, 0, 1, 0,  0,   9, 0, 1);  // down edge wraps 0 -> 9
    add(0, 0, 0, 0,  0,   9, 0, 0);  // borrow is one cycle
    add(0, 1, 0, 0,  0,   0, 1, 0);  // up edge wraps 9 -> 0
    add(0, 1, 0, 0,  0,   0, 0, 0);  // level held: no second step
    add(0, 0, 0, 0,  0,   0, 0, 0);
    add(0, 1, 0, 1, 12,   9, 0, 0);  // load saturates and beats up edge
    add(1, 0, 0, 0,  0,   9, 0, 0);
    add(1, 1, 0, 0,  0,   9, 0, 0);  // hold blocks up edge
    add(0, 0, 0, 0,  0,   9, 0, 0);
    add(0, 1, 1, 0,  0,   9, 0, 0);  // both edges cancel
    add(0, 0, 0, 0,  0,   9, 0, 0);
    add(1, 0, 0, 1,  5,   5, 0, 0);  // load overrides hold
    add(0, 1, 0, 0,  0,   6, 0, 0);
    add(0, 0, 1, 0,  0,   5, 0, 0);
    add(0, 0, 0, 1, 15,   9, 0, 0);  // max encodable value saturates
    add(0, 0, 0, 1, 10,   9, 0, 0);  // MODULUS saturates
    add(0, 0, 0, 1,  9,   9, 0, 0);  // MODULUS-1 loads as is
    add(0, 0, 0, 1,  0,   0, 0, 0);
    add(0, 0, 0, 0,  0,   0, 0, 0);

    en = 0; hold = 0; up = 0; down = 0; load = 0; lv = '0; cin = 0;
    c_en = 0; c_load = 0; c_lv = '0;

    // Reset acts with no clock edge.
    rst = 1'b1;
    #1;
    check("reset count", count, 3);
    check("reset carry", carry, 0);
    check("reset borrow", borrow, 0);
    check("reset tick", tick, 0);
    #6 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("idle en=0 count", count, 3);
    check("idle en=0 tick", tick, 0);

    // Table: manual steps, load, hold, cancel (prescaler idle, en=0).
    for (int i = 0; i < vecs.size(); i++) begin
      hold = vecs[i].hold; up = vecs[i].up; down = vecs[i].down;
      load = vecs[i].load; lv = vecs[i].lv;
      cyc();
      check($sformatf("vec%0d count", i), count, vecs[i].exp_count);
      check($sformatf("vec%0d carry", i), carry, vecs[i].exp_carry);
      check($sformatf("vec%0d borrow", i), borrow, vecs[i].exp_borrow);
      check($sformatf("vec%0d tick", i), tick, 0);
    end
    hold = 0; up = 0; down = 0; load = 0; lv = '0;

    // Auto count: prescaler starts at 0, a tick decision every 4th cycle.
    en = 1;
    exp_cnt = 0; n_ticks = 0; n_carry = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      exp_tk = (k % 4 == 0);
      exp_cy = 1'b0;
      if (exp_tk) begin
        exp_cnt = (exp_cnt == 9) ? 0 : exp_cnt + 1;
        exp_cy  = (exp_cnt == 0);
      end
      check($sformatf("auto%0d count", k), count, exp_cnt);
      check($sformatf("auto%0d tick", k), tick, exp_tk);
      check($sformatf("auto%0d carry", k), carry, exp_cy);
      if (tick === 1'b1) n_ticks++;
      if (carry === 1'b1) n_carry++;
    end
    check("auto tick total", n_ticks, 10);
    check("auto carry total", n_carry, 1);

    // Load with an up edge in the tick cycle: the load wins.
    repeat (3) cyc();
    load = 1; lv = 4'd12; up = 1;
    cyc();
    check("prio load count", count, 9);
    check("prio load carry", carry, 0);
    check("prio load tick", tick, 1);
    load = 0; lv = '0; up = 0;

    // Up edge in the tick cycle: one step only, and the tick is not deferred.
    repeat (3) cyc();
    check("pre-collision count", count, 9);
    up = 1;
    cyc();
    check("collision count", count, 0);
    check("collision carry", carry, 1);
    check("collision tick", tick, 1);
    up = 0;
    repeat (3) cyc();
    check("collision no defer", count, 0);
    cyc();
    check("next tick count", count, 1);
    check("next tick tick", tick, 1);

    // count_up held for 10 cycles gives a single step.
    en = 0; load = 1; lv = 4'd9;
    cyc();
    load = 0; up = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check($sformatf("held up%0d count", i), count, 0);
      check($sformatf("held up%0d carry", i), carry, (i == 0));
    end
    up = 0;

    // Cascade: c0 wraps 9 -> 0, and c1 steps one cycle later.
    c_load = 1; c_lv = 4'd9;
    cyc();
    check("casc load c0", c0_count, 9);
    c_load = 0; c_en = 1;
    repeat (3) cyc();
    check("casc pre c0", c0_count, 9);
    check("casc pre c1", c1_count, 0);
    cyc();
    check("casc wrap c0", c0_count, 0);
    check("casc wrap c0 carry", c0_carry, 1);
    check("casc wrap c1", c1_count, 0);
    cyc();
    check("casc ripple c1", c1_count, 1);
    check("casc ripple c0 carry", c0_carry, 0);
    check("casc ripple c1 carry", c1_carry, 0);
    repeat (2) cyc();
    cyc();
    check("casc c0 step", c0_count, 1);
    check("casc c0 tick", c0_tick, 1);

    // Mid-sequence reset clears every stage at once.
    #2 rst = 1'b1;
    #1;
    check("midrst c0", c0_count, 0);
    check("midrst c1", c1_count, 0);
    check("midrst c0 tick", c0_tick, 0);
    check("midrst dut", count, 3);
    #2 rst = 1'b0;
    repeat (3) cyc();
    check("resume c0 hold", c0_count, 0);
    cyc();
    check("resume c0 step", c0_count, 1);
    check("resume c0 tick", c0_tick, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
